// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: FSM encoding, default parameters,
// MIPS opcode values used by the core, and the fetch-address legality helper.
package fetch_sequencer_pkg;

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STALL = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int          DEF_IMEM_WORDS = 128;
  localparam int          DEF_CNT_W      = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // limit is the first illegal byte address (IMEM_WORDS*4)
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the core/instruction memory (master) and the
// fetch sequencer (slave).
interface fetch_sequencer_if #(parameter int CNT_W = 32);
  import fetch_sequencer_pkg::*;

  // fetch_valid qualifies instr_out in the same cycle; there is no ready, the
  // only backpressure is stall, which holds the PC and the presented word.
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump;
  logic [31:0]       jump_target;
  logic [31:0]       instruction;
  logic [31:0]       address;
  logic [31:0]       instr_out;
  logic              fetch_valid;
  logic [31:0]       pc_plus4;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  retire_count;
  logic [2:0]        state_dbg;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, instruction,
    input  address, instr_out, fetch_valid, pc_plus4, halted, fault,
           retire_count, state_dbg
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, instruction,
    output address, instr_out, fetch_valid, pc_plus4, halted, fault,
           retire_count, state_dbg
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Next-PC priority select (jump > branch > sequential) and the self-loop
// compare that signals the core has halted.
module fetch_sequencer_next_pc_mux (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        halt_hit
);

  logic        redirect;
  logic [31:0] target;

  always_comb begin
    redirect = jump | branch_taken;
    target   = jump ? jump_target : branch_target;
    next_pc  = redirect ? target : pc_plus4;
    // only a redirect can point back at itself; PC+4 never equals PC
    halt_hit = redirect && (target == pc);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, fetch FSM and retired-instruction counter for the
// single-cycle MIPS core.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int          CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [2:0]       state_q;
  logic [31:0]      pc_q;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic        pc_ok;
  logic        live;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        halt_hit;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_ok    = pc_legal(pc_q, PC_LIMIT);
  assign live     = pc_ok && ((state_q == ST_RUN) || (state_q == ST_STALL));

  fetch_sequencer_next_pc_mux u_next_pc_mux (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .next_pc       (next_pc),
    .halt_hit      (halt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= pc_ok ? ST_RUN : ST_FAULT;
          fault_q <= ~pc_ok;
        end
        ST_RUN, ST_STALL: begin
          if (!pc_ok) begin
            // PC stays at the offending value for debug
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (bus.stall) begin
            state_q <= ST_STALL;
          end else begin
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (halt_hit) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              pc_q    <= next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address      = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.fetch_valid  = live;
  assign bus.instr_out    = live ? bus.instruction : 32'h0;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;
  assign bus.retire_count = cnt_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_fetch_sequencer;

  localparam int          CNT_W    = 7;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] LIMIT    = 32'd512;

  typedef struct packed {
    logic [31:0]      address;
    logic             fv;
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] imem [0:127];
  logic [$bits(exp_t)-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0]      m_pc;
  bit               m_booted, m_halted, m_fault;
  logic [CNT_W-1:0] m_cnt;

  fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (128),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.instruction = imem[bus.address[8:2]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc < LIMIT);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_t'(exp_q.pop_front());
      check("address",      64'(bus.address),      64'(e.address));
      check("fetch_valid",  64'(bus.fetch_valid),  64'(e.fv));
      check("instr_out",    64'(bus.instr_out),    64'(e.instr));
      check("pc_plus4",     64'(bus.pc_plus4),     64'(e.pc4));
      check("halted",       64'(bus.halted),       64'(e.halted));
      check("fault",        64'(bus.fault),        64'(e.fault));
      check("retire_count", 64'(bus.retire_count), 64'(e.cnt));
    end
  end

  // driver: called at posedge+1, drives one cycle, returns at next posedge+1
  task automatic drive_cycle(input bit st, input bit br, input logic [31:0] bt,
                             input bit j, input logic [31:0] jt);
    exp_t        e;
    logic [31:0] tgt;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    e.fv      = m_booted && !m_halted && !m_fault && m_legal(m_pc);
    e.address = m_pc;
    e.instr   = e.fv ? imem[m_pc[8:2]] : 32'h0;
    e.pc4     = m_pc + 32'd4;
    e.halted  = m_halted;
    e.fault   = m_fault;
    e.cnt     = m_cnt;
    exp_q.push_back(e);
    if (m_halted || m_fault) begin
    end else if (!m_booted) begin
      m_booted = 1'b1;
      if (!m_legal(m_pc)) m_fault = 1'b1;
    end else if (!m_legal(m_pc)) begin
      m_fault = 1'b1;
    end else if (!st) begin
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      tgt = j ? jt : (br ? bt : m_pc + 32'd4);
      if ((j || br) && tgt == m_pc) m_halted = 1'b1;
      else m_pc = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, $urandom, 1'b0, $urandom);
  endtask

  // asserts reset mid-cycle and checks outputs clear before any edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_address",  64'(bus.address),      64'(RESET_PC));
    check("rst_fv",       64'(bus.fetch_valid),  64'd0);
    check("rst_instr",    64'(bus.instr_out),    64'd0);
    check("rst_halted",   64'(bus.halted),       64'd0);
    check("rst_fault",    64'(bus.fault),        64'd0);
    check("rst_count",    64'(bus.retire_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_pc     = RESET_PC;
    m_booted = 1'b0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    m_cnt    = '0;
  endtask

  function automatic logic [31:0] rand_target(input bit allow_bad);
    logic [31:0] t;
    t = 32'($urandom_range(0, 127)) << 2;
    if (allow_bad && $urandom_range(0, 30) == 0) t = t | 32'd2;
    if (allow_bad && $urandom_range(0, 30) == 0) t = t + LIMIT;
    if (!allow_bad && t == m_pc) t = (t + 32'd4) & 32'h0000_01FC;
    return t;
  endfunction

  task automatic rand_cycle(input bit allow_bad);
    drive_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, rand_target(allow_bad),
                $urandom_range(0, 9) == 0, rand_target(allow_bad));
  endtask

  initial begin
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.jump = 1'b0;
    bus.jump_target = '0;
    for (int i = 0; i < 128; i++) imem[i] = $urandom;

    do_reset();
    // BOOT then sequential fetch 0, 4, 8, C
    repeat (5) idle();
    // stall at 0x10 with a branch that must be ignored, then redirect on release
    repeat (3) drive_cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    repeat (2) idle();
    // at 0x28: jump wins over branch
    drive_cycle(1'b0, 1'b1, 32'h30, 1'b1, 32'h44);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h88);
    // self-loop at 0x88, then inputs ignored
    drive_cycle(1'b0, 1'b1, 32'h88, 1'b0, 32'h0);
    repeat (10) rand_cycle(1'b1);

    // misaligned and out-of-range jumps
    do_reset();
    idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h202);
    repeat (3) idle();
    do_reset();
    idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    repeat (3) idle();

    // asynchronous reset while running at 0x40
    do_reset();
    idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    do_reset();
    repeat (3) idle();

    // long legal run: drives the counter into saturation
    do_reset();
    repeat (300) rand_cycle(1'b0);

    // random runs with halts and faults allowed
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        rand_cycle(1'b1);
        if ((m_halted || m_fault) && $urandom_range(0, 7) == 0) break;
      end
    end

    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
